wb_cmd_master: RTL and testbench
================================

Name: wb_cmd_master

Overview:
- Single-outstanding bus master that turns queued command words into strobe/ack bus cycles for the peripheral set: digital out port, constant register, and digital in port.
- Sits directly upstream of the address decoder. Drives the shared ADR/DAT/STB/WE lines and consumes the ACK and read-data that the peripherals return.
- Replaces hand-driven bench stimulus. Adds a bus timeout so an unmapped address cannot hang the system.

Parameters:
- TIMEOUT, 16, maximum cycles oSTB is held without iACK before the transaction is aborted with error. Legal range 2..255.
- CNT_W, 8, width of the internal wait counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- iCLK  in  1  system clock; all logic rising-edge.
- iRST  in  1  synchronous, active-high reset.
- iCMD_VLD  in  1  command valid from the requester.
- oCMD_RDY  out  1  master can accept a command this cycle.
- iCMD_WE  in  1  1 = write, 0 = read.
- iCMD_ADR  in  32  target byte address.
- iCMD_DAT  in  32  write data; ignored for reads.
- oADR  out  32  bus address to the decoder and peripherals.
- oDAT  out  32  bus write data.
- oSTB  out  1  bus strobe to the decoder.
- oWE  out  1  bus write enable.
- iDAT  in  32  read data, already muxed from the selected peripheral.
- iACK  in  1  OR of the peripheral acks.
- oRSP_VLD  out  1  one-cycle response pulse.
- oRSP_DAT  out  32  read data; 0 for writes and errors.
- oRSP_ERR  out  1  1 = timeout abort; qualified by oRSP_VLD.
- oBUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (iRST sampled high at the edge):
  - state = IDLE.
  - oADR, oDAT, oRSP_DAT = 0.
  - oSTB, oWE, oRSP_VLD, oRSP_ERR, oBUSY = 0.
  - oCMD_RDY = 1 in the first cycle after reset release; it is held 0 while iRST is high.
  - Reset mid-transaction drops oSTB on the next edge and discards the pending response. No oRSP_VLD is issued.
- oCMD_RDY = 1 only in IDLE. A handshake is iCMD_VLD & oCMD_RDY at a rising edge.
- IDLE:
  - On handshake at edge N, latch iCMD_ADR/iCMD_DAT/iCMD_WE into oADR/oDAT/oWE.
  - Set oSTB = 1, clear the wait counter, go to BUS. oSTB is therefore visible in cycle N+1.
  - oDAT is latched even for reads; slaves ignore it.
- BUS:
  - oSTB, oADR, oDAT and oWE are held stable.
  - iACK is sampled every edge, including the first STB cycle (a zero-wait-state slave is legal).
  - On iACK = 1:
    - oSTB = 0, oWE = 0.
    - oRSP_DAT = (oWE ? 0 : iDAT), captured from the same edge.
    - oRSP_ERR = 0; go to RESP.
  - On iACK = 0: increment the counter.
  - If the counter reaches TIMEOUT-1 with no ack: oSTB = 0, oWE = 0, oRSP_DAT = 0, oRSP_ERR = 1; go to RESP. oSTB is therefore high for exactly TIMEOUT cycles on a timeout.
  - An ack on the same edge as the timeout wins: the transaction is reported as success.
- RESP:
  - oRSP_VLD = 1 for exactly one cycle; go to IDLE.
  - oCMD_RDY is 0 in RESP, so back-to-back commands have a minimum spacing of 3 cycles with a zero-wait slave.
  - oRSP_DAT and oRSP_ERR hold their values until the next response.
- oADR retains the last address after the transaction; oSTB = 0 qualifies it.
- iACK arriving while oSTB = 0 (IDLE/RESP) is ignored and produces no response.
- Command inputs are ignored outside the IDLE handshake.
- Counter saturates and never wraps. No arithmetic on data paths; all 32 bits pass through unchanged.

Test Plan:
- Write path: reset 2 cycles, then command WE=1 ADR=0x0200_0000 DAT=0x0000_0012 with a single-cycle ack.
  -> oSTB high 1 cycle with oWE=1 and oDAT=0x12; oRSP_VLD pulse with ERR=0 and DAT=0; out port A = 0x12.
- Read back: read 0x0200_0000.
  -> oWE=0 during STB; oRSP_DAT=0x0000_0012, ERR=0; response 2 cycles after the handshake edge.
- Const read with wait states: read 0x0200_0100 with the ack delayed 3 cycles.
  -> oSTB high 4 cycles with ADR stable; oRSP_DAT=0x0123_4567.
- Input port: drive the input port with 0xCD, then read 0x0200_0800.
  -> oRSP_DAT=0x0000_00CD.
- Timeout: read 0x0300_0000 (unmapped, no ack), TIMEOUT=16.
  -> oSTB high exactly 16 cycles; oRSP_VLD with ERR=1, DAT=0; oCMD_RDY returns 1 one cycle after RESP.
- Corner cases:
  - iCMD_VLD held high across 3 commands: exactly 3 handshakes, and oCMD_RDY is never 1 during BUS/RESP.
  - iRST asserted during BUS: oSTB=0 next edge, no oRSP_VLD.
  - Stray iACK in IDLE: no response.

Source files
------------

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-outstanding strobe/ack bus master.
// Accepts one command word at a time and turns it into one bus cycle on the
// shared ADR/DAT/STB/WE lines. It then reports exactly one response, either
// an ack with data or a timeout error. A watchdog counter bounds every cycle,
// so an unmapped address cannot hang the requester.
module wb_cmd_master #(
    parameter int TIMEOUT = 16,   // max cycles oSTB may stay high without iACK (2..255)
    parameter int CNT_W   = 8     // wait counter width, 2**CNT_W > TIMEOUT
) (
    input  logic        iCLK,
    input  logic        iRST,
    // command side
    input  logic        iCMD_VLD,
    output logic        oCMD_RDY,
    input  logic        iCMD_WE,
    input  logic [31:0] iCMD_ADR,
    input  logic [31:0] iCMD_DAT,
    // bus side
    output logic [31:0] oADR,
    output logic [31:0] oDAT,
    output logic        oSTB,
    output logic        oWE,
    input  logic [31:0] iDAT,
    input  logic        iACK,
    // response side
    output logic        oRSP_VLD,
    output logic [31:0] oRSP_DAT,
    output logic        oRSP_ERR,
    output logic        oBUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value at which the cycle is abandoned. When the counter has
    // this value, oSTB has already been high for TIMEOUT cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           stateReg;
    logic [CNT_W-1:0] waitCntReg;
    logic             cmdFire;

    // Ready only in IDLE and never while reset is applied. Gating by iRST
    // makes ready drop at once during reset and return in the first cycle
    // after release.
    assign oCMD_RDY = (stateReg == IDLE) && !iRST;
    assign cmdFire  = iCMD_VLD && oCMD_RDY;

    // Master FSM: latches the command, runs the strobe/ack cycle with its
    // watchdog, and issues the one-cycle response pulse.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            stateReg   <= IDLE;
            waitCntReg <= '0;
            oADR       <= '0;
            oDAT       <= '0;
            oSTB       <= 1'b0;
            oWE        <= 1'b0;
            oRSP_VLD   <= 1'b0;
            oRSP_DAT   <= '0;
            oRSP_ERR   <= 1'b0;
            oBUSY      <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    // Write data is latched for reads too. Slaves ignore it
                    // when oWE is low, and latching it always saves a mux.
                    if (cmdFire) begin
                        oADR       <= iCMD_ADR;
                        oDAT       <= iCMD_DAT;
                        oWE        <= iCMD_WE;
                        oSTB       <= 1'b1;
                        oBUSY      <= 1'b1;
                        waitCntReg <= '0;
                        stateReg   <= BUS;
                    end
                end

                BUS: begin
                    // iACK is tested before the timeout, so an ack on the
                    // last allowed edge still completes as a success.
                    if (iACK) begin
                        oSTB     <= 1'b0;
                        oWE      <= 1'b0;
                        oRSP_DAT <= oWE ? 32'd0 : iDAT;
                        oRSP_ERR <= 1'b0;
                        oRSP_VLD <= 1'b1;
                        stateReg <= RESP;
                    end else if (waitCntReg == CNT_LAST) begin
                        oSTB     <= 1'b0;
                        oWE      <= 1'b0;
                        oRSP_DAT <= '0;
                        oRSP_ERR <= 1'b1;
                        oRSP_VLD <= 1'b1;
                        stateReg <= RESP;
                    end else if (waitCntReg != CNT_MAX) begin
                        waitCntReg <= waitCntReg + 1'b1;
                    end
                end

                RESP: begin
                    // The pulse lasts a single cycle. oRSP_DAT and oRSP_ERR
                    // keep their values until the next response.
                    oRSP_VLD <= 1'b0;
                    oBUSY    <= 1'b0;
                    stateReg <= IDLE;
                end

                default: begin
                    oSTB     <= 1'b0;
                    oWE      <= 1'b0;
                    oRSP_VLD <= 1'b0;
                    oBUSY    <= 1'b0;
                    stateReg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Testbench for wb_cmd_master. A small behavioural peripheral set is modelled
// here: out port A at 0x0200_0000, a constant register at 0x0200_0100 and an
// input port at 0x0200_0800. The ack delay is programmable from the bench.
module tb_wb_cmd_master;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        cmdVld;
    logic        cmdRdy;
    logic        cmdWe;
    logic [31:0] cmdAdr;
    logic [31:0] cmdDat;
    logic [31:0] busAdr;
    logic [31:0] busDat;
    logic        busStb;
    logic        busWe;
    logic [31:0] slvDat;
    logic        busAck;
    logic        rspVld;
    logic [31:0] rspDat;
    logic        rspErr;
    logic        busy;

    int          checks   = 0;
    int          failures = 0;

    // peripheral model state
    int          ackDelay = 0;
    int          slvCnt   = 0;
    logic        slvHit;
    logic        strayAck = 1'b0;
    logic [31:0] portA;
    logic [31:0] inPort   = 32'h0;

    wb_cmd_master #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .iCLK     (clk),
        .iRST     (rst),
        .iCMD_VLD (cmdVld),
        .oCMD_RDY (cmdRdy),
        .iCMD_WE  (cmdWe),
        .iCMD_ADR (cmdAdr),
        .iCMD_DAT (cmdDat),
        .oADR     (busAdr),
        .oDAT     (busDat),
        .oSTB     (busStb),
        .oWE      (busWe),
        .iDAT     (slvDat),
        .iACK     (busAck),
        .oRSP_VLD (rspVld),
        .oRSP_DAT (rspDat),
        .oRSP_ERR (rspErr),
        .oBUSY    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // address decode + read mux + delayed ack of the peripheral set
    always_comb begin
        slvDat = 32'h0;
        slvHit = 1'b0;
        case (busAdr)
            32'h0200_0000: begin slvDat = portA;         slvHit = 1'b1; end
            32'h0200_0100: begin slvDat = 32'h0123_4567; slvHit = 1'b1; end
            32'h0200_0800: begin slvDat = inPort;        slvHit = 1'b1; end
            default:       begin slvDat = 32'h0;         slvHit = 1'b0; end
        endcase
        busAck = ((busStb === 1'b1) && slvHit && (slvCnt == ackDelay)) || strayAck;
    end

    // wait-state counter and out port A register
    always @(posedge clk) begin
        slvCnt <= (busStb === 1'b1) ? slvCnt + 1 : 0;
        if (rst)
            portA <= 32'h0;
        else if (busAck && busStb && busWe && busAdr == 32'h0200_0000)
            portA <= busDat;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        int          delay;
        logic        expErr;
        logic [31:0] expDat;
        int          expStb;
        int          expLat;
        logic [31:0] expPort;
    } vec_t;

    vec_t vecs[8];

    // One command through the master; all checks for one transaction.
    task automatic runCmd(input vec_t v);
        int          stb;
        int          lat;
        int          guard;
        logic        stable;
        logic        gotRsp;
        logic [31:0] rDat;
        logic        rErr;
        ackDelay = v.delay;
        guard = 0;
        while (cmdRdy !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({v.name, "_rdy"}, 32'(cmdRdy), 32'd1);
        cmdVld = 1'b1; cmdWe = v.we; cmdAdr = v.adr; cmdDat = v.dat;
        @(negedge clk);
        // scramble the command inputs; they must be ignored from here on
        cmdVld = 1'b0; cmdWe = ~v.we; cmdAdr = ~v.adr; cmdDat = ~v.dat;
        stb = 0; lat = 1; stable = 1'b1; gotRsp = 1'b0; rDat = 32'h0; rErr = 1'b0;
        while (!gotRsp && lat < 100) begin
            if (busStb === 1'b1) begin
                stb++;
                if (busAdr !== v.adr || busWe !== v.we || (v.we && busDat !== v.dat))
                    stable = 1'b0;
            end
            if (rspVld === 1'b1) begin
                gotRsp = 1'b1;
                rDat = rspDat;
                rErr = rspErr;
                if (busStb !== 1'b0) stable = 1'b0;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        check({v.name, "_rsp_seen"}, 32'(gotRsp), 32'd1);
        check({v.name, "_latency"}, 32'(lat), 32'(v.expLat));
        check({v.name, "_stb_cycles"}, 32'(stb), 32'(v.expStb));
        check({v.name, "_bus_stable"}, 32'(stable), 32'd1);
        check({v.name, "_rsp_err"}, 32'(rErr), 32'(v.expErr));
        check({v.name, "_rsp_dat"}, rDat, v.expDat);
        $display("txn %s we=%0d adr=0x%08h lat=%0d stb=%0d err=%0d dat=0x%08h",
                 v.name, v.we, v.adr, lat, stb, rErr, rDat);
        @(negedge clk);
        check({v.name, "_pulse_one_cycle"}, 32'(rspVld), 32'd0);
        check({v.name, "_rdy_after_resp"}, 32'(cmdRdy), 32'd1);
        check({v.name, "_idle_not_busy"}, 32'(busy), 32'd0);
        check({v.name, "_rsp_dat_hold"}, rspDat, v.expDat);
        check({v.name, "_port_a"}, portA, v.expPort);
    endtask

    initial begin
        int hs;
        int hs3At;
        int rsps;
        int bad;
        int cyc;

        vecs[0] = '{"wr_porta",       1'b1, 32'h0200_0000, 32'h0000_0012, 0,  1'b0, 32'h0,          1,  2,  32'h12};
        vecs[1] = '{"rd_porta",       1'b0, 32'h0200_0000, 32'hDEAD_BEEF, 0,  1'b0, 32'h0000_0012,  1,  2,  32'h12};
        vecs[2] = '{"rd_const_ws3",   1'b0, 32'h0200_0100, 32'h0,         3,  1'b0, 32'h0123_4567,  4,  5,  32'h12};
        vecs[3] = '{"rd_inport",      1'b0, 32'h0200_0800, 32'h0,         0,  1'b0, 32'h0000_00CD,  1,  2,  32'h12};
        vecs[4] = '{"timeout",        1'b0, 32'h0300_0000, 32'h0,         0,  1'b1, 32'h0,          16, 17, 32'h12};
        vecs[5] = '{"ack_at_timeout", 1'b0, 32'h0200_0100, 32'h0,         15, 1'b0, 32'h0123_4567,  16, 17, 32'h12};
        vecs[6] = '{"wr_ws2",         1'b1, 32'h0200_0000, 32'hA5A5_5A5A, 2,  1'b0, 32'h0,          3,  4,  32'hA5A5_5A5A};
        vecs[7] = '{"rd_after_wr",    1'b0, 32'h0200_0000, 32'h0,         1,  1'b0, 32'hA5A5_5A5A,  2,  3,  32'hA5A5_5A5A};

        rst = 1'b1; cmdVld = 1'b0; cmdWe = 1'b0; cmdAdr = 32'h0; cmdDat = 32'h0;

        // reset: two edges with iRST high
        @(negedge clk);
        check("rst_rdy_low", 32'(cmdRdy), 32'd0);
        @(negedge clk);
        check("rst_stb", 32'(busStb), 32'd0);
        check("rst_adr", busAdr, 32'h0);
        check("rst_rsp", {rspDat[29:0], rspVld, rspErr}, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_rdy_after_release", 32'(cmdRdy), 32'd1);
        $display("txn reset done rdy=%0d", cmdRdy);

        inPort = 32'h0000_00CD;
        for (int i = 0; i < 8; i++) begin
            runCmd(vecs[i]);
        end

        // iCMD_VLD held high across three commands (zero-wait const reads)
        @(negedge clk);
        ackDelay = 0;
        cmdVld = 1'b1; cmdWe = 1'b0; cmdAdr = 32'h0200_0100; cmdDat = 32'h0;
        hs = 0; hs3At = -1; rsps = 0; bad = 0;
        for (cyc = 0; cyc < 20; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cmdRdy && (busStb || rspVld || busy)) bad++;
            if (rspVld) rsps++;
            if (cmdVld && cmdRdy) begin
                hs++;
                if (hs == 3) begin
                    hs3At = cyc;
                    @(posedge clk);
                    #1 cmdVld = 1'b0;
                end
            end
        end
        check("b2b_handshakes", 32'(hs), 32'd3);
        check("b2b_third_hs_cycle", 32'(hs3At), 32'd6);
        check("b2b_responses", 32'(rsps), 32'd3);
        check("b2b_rdy_in_bus_resp", 32'(bad), 32'd0);
        $display("txn back_to_back hs=%0d third_at=%0d rsps=%0d", hs, hs3At, rsps);

        // reset asserted during BUS: strobe drops, no response
        @(negedge clk);
        cmdVld = 1'b1; cmdWe = 1'b0; cmdAdr = 32'h0300_0000;
        @(negedge clk);
        cmdVld = 1'b0;
        check("rstbus_stb_before", 32'(busStb), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstbus_stb_dropped", 32'(busStb), 32'd0);
        check("rstbus_rdy_in_rst", 32'(cmdRdy), 32'd0);
        check("rstbus_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        rsps = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rspVld) rsps++;
        end
        check("rstbus_no_rsp", 32'(rsps), 32'd0);
        check("rstbus_rdy_back", 32'(cmdRdy), 32'd1);
        $display("txn reset_in_bus rsps=%0d", rsps);

        // stray ack while idle: ignored
        strayAck = 1'b1;
        rsps = 0; bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rspVld) rsps++;
            if (busy || busStb) bad++;
        end
        strayAck = 1'b0;
        @(negedge clk);
        if (rspVld) rsps++;
        check("stray_ack_no_rsp", 32'(rsps), 32'd0);
        check("stray_ack_idle", 32'(bad), 32'd0);
        $display("txn stray_ack rsps=%0d", rsps);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
